// File: rtl/bp_core_lce_req_arb.sv
// Two-port LCE request arbiter: per-port input FIFO, outstanding-request credits,
// round-robin selection, and an output that holds steady until the consumer takes it.
module bp_core_lce_req_arb #(
    parameter int req_width_p       = 96,
    parameter int fifo_els_p        = 2,
    parameter int max_outstanding_p = 4,
    localparam int credit_width_lp  = $clog2(max_outstanding_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [1:0][req_width_p-1:0]  lce_req_i,
    input  logic [1:0]                   lce_req_v_i,
    output logic [1:0]                   lce_req_ready_o,
    output logic [req_width_p-1:0]       lce_req_o,
    output logic                         lce_req_src_o,
    output logic                         lce_req_v_o,
    input  logic                         lce_req_yumi_i,
    input  logic [1:0]                   req_done_i,
    output logic [1:0]                   credits_full_o,
    output logic [1:0]                   credits_empty_o
);
    localparam int ptr_w_lp = $clog2(fifo_els_p);
    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam logic [ptr_w_lp-1:0]        last_ptr_lp = ptr_w_lp'(fifo_els_p - 1);
    localparam logic [cnt_w_lp-1:0]        full_cnt_lp = cnt_w_lp'(fifo_els_p);
    localparam logic [credit_width_lp-1:0] max_cred_lp = credit_width_lp'(max_outstanding_p);

    logic [1:0]                  elig;
    logic [1:0]                  enq;
    logic [1:0]                  deq;
    logic [1:0][req_width_p-1:0] head;
    logic                        sel;
    logic                        arb_v;
    logic                        lock_v_q;
    logic                        lock_sel_q;
    logic                        last_grant_q;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [req_width_p-1:0]     mem_q [fifo_els_p];
            logic [ptr_w_lp-1:0]        rptr_q;
            logic [ptr_w_lp-1:0]        wptr_q;
            logic [cnt_w_lp-1:0]        cnt_q;
            logic [cnt_w_lp-1:0]        cnt_d;
            logic [credit_width_lp-1:0] credit_q;
            logic [credit_width_lp-1:0] credit_d;

            assign lce_req_ready_o[gi] = reset_n_i & (cnt_q != full_cnt_lp);
            assign enq[gi]  = lce_req_v_i[gi] & lce_req_ready_o[gi];
            assign deq[gi]  = lce_req_yumi_i & arb_v & (sel == 1'(gi));
            assign elig[gi] = (cnt_q != '0) & (credit_q < max_cred_lp);
            assign head[gi] = mem_q[rptr_q];

            assign credits_full_o[gi]  = reset_n_i & (credit_q == max_cred_lp);
            assign credits_empty_o[gi] = ~reset_n_i | (credit_q == '0);

            always_comb begin
                cnt_d = cnt_q + cnt_w_lp'(enq[gi]) - cnt_w_lp'(deq[gi]);
            end

            // A grant and a retire in the same cycle cancel; a lone retire at zero is dropped.
            always_comb begin
                credit_d = credit_q;
                if (deq[gi] && !req_done_i[gi]) begin
                    credit_d = credit_q + credit_width_lp'(1);
                end else if (!deq[gi] && req_done_i[gi] && (credit_q != '0)) begin
                    credit_d = credit_q - credit_width_lp'(1);
                end
            end

            always_ff @(posedge clk_i) begin
                if (!reset_n_i) begin
                    rptr_q   <= '0;
                    wptr_q   <= '0;
                    cnt_q    <= '0;
                    credit_q <= '0;
                end else begin
                    cnt_q    <= cnt_d;
                    credit_q <= credit_d;
                    if (enq[gi]) begin
                        wptr_q <= (wptr_q == last_ptr_lp) ? '0 : wptr_q + ptr_w_lp'(1);
                    end
                    if (deq[gi]) begin
                        rptr_q <= (rptr_q == last_ptr_lp) ? '0 : rptr_q + ptr_w_lp'(1);
                    end
                end
            end

            // Storage carries no reset; occupancy alone decides which entries are live.
            always_ff @(posedge clk_i) begin
                if (enq[gi]) begin
                    mem_q[wptr_q] <= lce_req_i[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        if (lock_v_q) begin
            sel = lock_sel_q;
        end else if (&elig) begin
            sel = ~last_grant_q;
        end else begin
            sel = elig[1];
        end
    end

    assign arb_v         = reset_n_i & (lock_v_q | (|elig));
    assign lce_req_v_o   = arb_v;
    assign lce_req_src_o = arb_v & sel;
    assign lce_req_o     = arb_v ? head[sel] : '0;

    // An offered but unaccepted request pins the selection until it is taken.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            lock_v_q     <= 1'b0;
            lock_sel_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (arb_v) begin
            if (lce_req_yumi_i) begin
                lock_v_q     <= 1'b0;
                last_grant_q <= sel;
            end else begin
                lock_v_q   <= 1'b1;
                lock_sel_q <= sel;
            end
        end
    end
endmodule
